// File: rtl/exec_seq_pkg.sv
// Shared widths, opcode constants, instruction layout and state encoding for exec_seq.
// The HALT state only exists when EXEC_SEQ_BREAK_EN is defined.
package exec_seq_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 11;

   localparam logic [3:0] OP_ALU_LAST = 4'h9;
   localparam logic [3:0] OP_PCZERO   = 4'h8;
   localparam logic [3:0] OP_PCNZERO  = 4'h9;
   localparam logic [3:0] OP_GOTO     = 4'hA;
   localparam logic [3:0] OP_MOVWF    = 4'hB;
   localparam logic [3:0] ALU_NOP     = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_READ,
      S_EXEC,
      S_WRITE
`ifdef EXEC_SEQ_BREAK_EN
      ,
      S_HALT
`endif
   } state_t;

   typedef struct packed {
      logic [3:0]        opcode;
      logic              dest;
      logic [ADDR_W-1:0] addr;
   } instr_t;

   function automatic logic is_alu(input logic [3:0] op);
      return (op <= OP_ALU_LAST);
   endfunction

endpackage

// File: rtl/exec_seq.sv
// Multi-cycle fetch/read/exec/write sequencer in front of an external ALU; owns PC, W and flags.
// Optional breakpoint/HALT support is compiled in with EXEC_SEQ_BREAK_EN.
module exec_seq
   import exec_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_mem,
   output logic [DATA_W-1:0] alu_wreg,
   output logic              alu_carry_in,
   output logic              alu_zero_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry_out,
   input  logic              alu_zero_out,
   input  logic              alu_pc_skip,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] w,
   output logic              carry,
   output logic              zero
`ifdef EXEC_SEQ_BREAK_EN
   ,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic              resume,
   output logic              halted
`endif
);

   state_t            r_state;
   state_t            w_state_nxt;
   instr_t            r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_w;
   logic              r_carry;
   logic              r_zero;
   logic [DATA_W-1:0] r_operand;
   logic [DATA_W-1:0] r_result;
   logic              r_skip;

   instr_t            w_fetched;
   logic              w_ir_alu;
   logic              w_skip_now;
   logic              w_halt_req;
   logic              w_fetch_done;
   logic [ADDR_W-1:0] w_pc_exec;
   logic [ADDR_W-1:0] w_pc_write;

   assign w_fetched    = instr_t'(imem_rdata);
   assign w_ir_alu     = is_alu(r_ir.opcode);
   assign w_skip_now   = alu_pc_skip && (r_ir.opcode == OP_PCZERO || r_ir.opcode == OP_PCNZERO);
   assign w_fetch_done = (r_state == S_FETCH) && imem_ack && !w_halt_req;
   assign w_pc_exec    = r_pc + ADDR_W'(1) + ADDR_W'(w_skip_now);
   assign w_pc_write   = r_pc + ADDR_W'(1) + ADDR_W'(r_skip);

`ifdef EXEC_SEQ_BREAK_EN
   logic r_bypass;
   logic r_fetch_held;

   // The break decision is only taken before a fetch request has gone out, so a
   // request already on the bus is never withdrawn.
   assign w_halt_req = (r_state == S_FETCH) && bp_en && (r_pc == bp_addr)
                       && !r_bypass && !r_fetch_held;
   assign halted     = (r_state == S_HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bypass     <= 1'b0;
         r_fetch_held <= 1'b0;
      end else begin
         r_fetch_held <= (r_state == S_FETCH) && !w_halt_req && !imem_ack;
         if (r_state == S_HALT && resume)
            r_bypass <= 1'b1;
         else if (w_fetch_done)
            r_bypass <= 1'b0;
      end
   end
`else
   assign w_halt_req = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_state_nxt;
   end

   // NOTE: w_state_nxt is defaulted before the case so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH: begin
            if (imem_ack) begin
               if (is_alu(w_fetched.opcode))           w_state_nxt = S_READ;
               else if (w_fetched.opcode == OP_MOVWF) w_state_nxt = S_WRITE;
               else                                   w_state_nxt = S_EXEC;
            end
         end
         S_READ:  if (dmem_ack) w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = (w_ir_alu && r_ir.dest) ? S_WRITE : S_FETCH;
         S_WRITE: if (dmem_ack) w_state_nxt = S_FETCH;
`ifdef EXEC_SEQ_BREAK_EN
         S_HALT:  if (resume) w_state_nxt = S_FETCH;
`endif
         default: w_state_nxt = S_FETCH;
      endcase
`ifdef EXEC_SEQ_BREAK_EN
      if (w_halt_req) w_state_nxt = S_HALT;
`endif
   end

   // Requests are gated by rst so an asserted reset drops them without waiting for a clock.
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      alu_op   = ALU_NOP;
      if (!rst) begin
         imem_req = (r_state == S_FETCH) && !w_halt_req;
         dmem_req = (r_state == S_READ) || (r_state == S_WRITE);
         dmem_we  = (r_state == S_WRITE);
      end
      if (r_state == S_EXEC && w_ir_alu) alu_op = r_ir.opcode;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ir      <= '0;
         r_pc      <= '0;
         r_w       <= '0;
         r_carry   <= 1'b0;
         r_zero    <= 1'b0;
         r_operand <= '0;
         r_result  <= '0;
         r_skip    <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_fetch_done) begin
                  r_ir   <= w_fetched;
                  r_skip <= 1'b0;
               end
            end
            S_READ: if (dmem_ack) r_operand <= dmem_rdata;
            S_EXEC: begin
               if (w_ir_alu) begin
                  r_carry <= alu_carry_out;
                  r_zero  <= alu_zero_out;
                  if (r_ir.dest) begin
                     r_result <= alu_result;
                     r_skip   <= w_skip_now;
                  end else begin
                     r_w  <= alu_result;
                     r_pc <= w_pc_exec;
                  end
               end else if (r_ir.opcode == OP_GOTO) begin
                  r_pc <= r_ir.addr;
               end else begin
                  r_pc <= w_pc_exec;
               end
            end
            S_WRITE: if (dmem_ack) r_pc <= w_pc_write;
            default: ;
         endcase
      end
   end

   assign imem_addr    = r_pc;
   assign dmem_addr    = r_ir.addr;
   assign dmem_wdata   = w_ir_alu ? r_result : r_w;
   assign alu_mem      = r_operand;
   assign alu_wreg     = r_w;
   assign alu_carry_in = r_carry;
   assign alu_zero_in  = r_zero;
   assign pc           = r_pc;
   assign w            = r_w;
   assign carry        = r_carry;
   assign zero         = r_zero;

endmodule

// File: tb/tb_exec_seq.sv
// Self-checking bench for exec_seq: memory responders with configurable ack delay, a stand-in ALU,
// and an instruction-level reference model checked at every fetch and every data access.
module tb_exec_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack;
   logic [10:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [10:0] dmem_addr;
   logic [15:0] dmem_wdata, dmem_rdata;
   logic [3:0]  alu_op;
   logic [15:0] alu_mem, alu_wreg, alu_result;
   logic        alu_carry_in, alu_zero_in, alu_carry_out, alu_zero_out, alu_pc_skip;
   logic [10:0] pc;
   logic [15:0] w;
   logic        carry, zero;
`ifdef EXEC_SEQ_BREAK_EN
   logic        bp_en = 1'b0;
   logic [10:0] bp_addr = 11'h0;
   logic        resume = 1'b0;
   logic        halted;
`endif

   always #5 clk = ~clk;

   exec_seq dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .alu_op(alu_op), .alu_mem(alu_mem), .alu_wreg(alu_wreg),
      .alu_carry_in(alu_carry_in), .alu_zero_in(alu_zero_in),
      .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_zero_out(alu_zero_out),
      .alu_pc_skip(alu_pc_skip),
      .pc(pc), .w(w), .carry(carry), .zero(zero)
`ifdef EXEC_SEQ_BREAK_EN
      , .bp_en(bp_en), .bp_addr(bp_addr), .resume(resume), .halted(halted)
`endif
   );

   // Stand-in ALU: returns {skip, zero_out, carry_out, result}. Ops 0-7 drive a
   // nonzero-prone skip on purpose; only ops 8/9 may move the PC.
   function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [15:0] m,
                                         input logic [15:0] wv, input logic ci, input logic zi);
      logic [16:0] s;
      logic [15:0] r;
      logic        c, z, k;
      c = ci;
      r = 16'h0;
      s = 17'h0;
      case (op)
         4'h0: r = m;
         4'h1: r = wv & m;
         4'h2: begin s = {1'b0, wv} + {1'b0, m}; r = s[15:0]; c = s[16]; end
         4'h3: begin r = m - wv; c = (m >= wv); end
         4'h4: r = wv | m;
         4'h5: r = wv ^ m;
         4'h6: begin s = {1'b0, m} + 17'd1; r = s[15:0]; c = s[16]; end
         4'h7: r = ~m;
         4'h8, 4'h9: r = m;
         default: begin r = 16'hBEEF; c = ~ci; end
      endcase
      if (op == 4'h8 || op == 4'h9) z = zi;
      else if (op > 4'h9)           z = ~zi;
      else                          z = (r == 16'h0);
      if (op == 4'h8)      k = (m != 16'h0);
      else if (op == 4'h9) k = (m == 16'h0);
      else                 k = r[0];
      return {k, z, c, r};
   endfunction

   assign {alu_pc_skip, alu_zero_out, alu_carry_out, alu_result} =
      alu_f(alu_op, alu_mem, alu_wreg, alu_carry_in, alu_zero_in);

   logic [15:0] imem [0:2047];
   logic [15:0] dmem [0:2047];
   logic [15:0] mmem [0:2047];

   logic [10:0] m_pc;
   logic [15:0] m_w;
   logic        m_c, m_z;
   logic [26:0] exp_wr [$];
   logic [10:0] exp_rd [$];
   int          fetch_cyc [$];
   logic [10:0] fetch_addr [$];
   int          fetch_n = 0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          i_fix = 0, d_fix = 0;
   bit          i_rand = 1'b0, d_rand = 1'b0;
   int          i_cur = 0, d_cur = 0, i_wait = 0, d_wait = 0;
   logic [10:0] last_wr_addr = 11'h0;
   logic [15:0] last_wr_data = 16'h0;

   // Architectural effect of one instruction, applied when it is fetched.
   task automatic model_exec(input logic [15:0] ir);
      logic [3:0]  op;
      logic        dst;
      logic [10:0] a;
      logic [18:0] r;
      op  = ir[15:12];
      dst = ir[11];
      a   = ir[10:0];
      if (op <= 4'h9) begin
         exp_rd.push_back(a);
         r   = alu_f(op, mmem[a], m_w, m_c, m_z);
         m_c = r[16];
         m_z = r[17];
         if (dst) begin
            mmem[a] = r[15:0];
            exp_wr.push_back({a, r[15:0]});
         end else begin
            m_w = r[15:0];
         end
         m_pc = m_pc + 11'd1 + ((op >= 4'h8) ? {10'd0, r[18]} : 11'd0);
      end else if (op == 4'hA) begin
         m_pc = a;
      end else if (op == 4'hB) begin
         mmem[a] = m_w;
         exp_wr.push_back({a, m_w});
         m_pc = m_pc + 11'd1;
      end else begin
         m_pc = m_pc + 11'd1;
      end
   endtask

   // Memory responders; handshakes decided here are taken by the DUT at the next rising edge.
   always @(negedge clk) begin
      logic [26:0] e;
      cyc++;
      if (rst) begin
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         i_wait = 0;
         d_wait = 0;
         i_cur = i_rand ? int'($urandom_range(0, 2)) : i_fix;
         d_cur = d_rand ? int'($urandom_range(0, 2)) : d_fix;
         m_pc = 11'h0; m_w = 16'h0; m_c = 1'b0; m_z = 1'b0;
         exp_rd.delete(); exp_wr.delete(); fetch_cyc.delete(); fetch_addr.delete();
         fetch_n = 0;
      end else begin
         if (imem_req && i_wait >= i_cur) begin
            imem_ack = 1'b1;
            imem_rdata = imem[imem_addr];
            checks++;
            if (imem_addr !== m_pc || pc !== m_pc || w !== m_w || carry !== m_c || zero !== m_z || alu_op !== 4'hF) begin
               errors++;
               $display("FAIL fetch_state: got addr=%h pc=%h w=%h c=%b z=%b alu_op=%h, want addr=pc=%h w=%h c=%b z=%b alu_op=f",
                        imem_addr, pc, w, carry, zero, alu_op, m_pc, m_w, m_c, m_z);
            end
            fetch_cyc.push_back(cyc);
            fetch_addr.push_back(imem_addr);
            fetch_n++;
            model_exec(imem[m_pc]);
            i_wait = 0;
            i_cur = i_rand ? int'($urandom_range(0, 2)) : i_fix;
         end else begin
            imem_ack = 1'b0;
            imem_rdata = 16'($urandom);
            if (imem_req) i_wait++;
         end

         if (dmem_req && d_wait >= d_cur) begin
            dmem_ack = 1'b1;
            checks++;
            if (dmem_we) begin
               dmem_rdata = 16'($urandom);
               e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 27'h7FFFFFF;
               if ({dmem_addr, dmem_wdata} !== e) begin
                  errors++;
                  $display("FAIL dmem_write: got addr=%h data=%h, want addr=%h data=%h",
                           dmem_addr, dmem_wdata, e[26:16], e[15:0]);
               end
               dmem[dmem_addr] = dmem_wdata;
               last_wr_addr = dmem_addr;
               last_wr_data = dmem_wdata;
            end else begin
               dmem_rdata = dmem[dmem_addr];
               e = {(exp_rd.size() > 0) ? exp_rd.pop_front() : 11'h7FF, 16'h0};
               if (dmem_addr !== e[26:16] || exp_wr.size() > 1) begin
                  errors++;
                  $display("FAIL dmem_read: got addr=%h, want addr=%h", dmem_addr, e[26:16]);
               end
            end
            d_wait = 0;
            d_cur = d_rand ? int'($urandom_range(0, 2)) : d_fix;
         end else begin
            dmem_ack = 1'b0;
            dmem_rdata = 16'($urandom);
            if (dmem_req) d_wait++;
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic clear_mems();
      for (int i = 0; i < 2048; i++) begin
         imem[i] = 16'hC000;
         dmem[i] = 16'h0;
         mmem[i] = 16'h0;
      end
   endtask

   task automatic set_d(input logic [10:0] a, input logic [15:0] v);
      dmem[a] = v;
      mmem[a] = v;
   endtask

   task automatic wait_fetches(input int n, input int budget, input string tag);
      int left;
      left = budget;
      while (fetch_n < n && left > 0) begin
         @(negedge clk);
         left--;
      end
      #1;
      checks++;
      if (fetch_n < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d fetches, want %0d", tag, fetch_n, n);
      end
   endtask

   task automatic test_reset();
      int left;
      clear_mems();
      imem[0] = 16'h0007;
      imem[1] = 16'h0005;
      set_d(11'h7, 16'h1234);
      i_fix = 0; d_fix = 10;
      apply_reset();
      #1;
      checks++;
      if (pc !== 11'h0 || w !== 16'h0 || carry !== 1'b0 || zero !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 11'h0) begin
         errors++;
         $display("FAIL reset_values: got pc=%h w=%h c=%b z=%b req=%b addr=%h, want 0/0/0/0/1/0",
                  pc, w, carry, zero, imem_req, imem_addr);
      end
      left = 200;
      while (!(fetch_n >= 2 && dmem_req === 1'b1) && left > 0) begin
         @(negedge clk);
         left--;
      end
      checks++;
      if (w !== 16'h1234 || dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_setup: got w=%h dmem_req=%b, want w=1234 dmem_req=1", w, dmem_req);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dmem_req !== 1'b0 || imem_req !== 1'b0 || dmem_we !== 1'b0 || pc !== 11'h0 || w !== 16'h0 || alu_op !== 4'hF) begin
         errors++;
         $display("FAIL reset_async: got dmem_req=%b imem_req=%b we=%b pc=%h w=%h alu_op=%h, want 0/0/0/0/0/f",
                  dmem_req, imem_req, dmem_we, pc, w, alu_op);
      end
      d_fix = 0;
      apply_reset();
      wait_fetches(2, 100, "reset");
      checks++;
      if (fetch_addr[0] !== 11'h0 || fetch_addr[1] !== 11'h1) begin
         errors++;
         $display("FAIL reset_restart: got fetch %h,%h, want 000,001", fetch_addr[0], fetch_addr[1]);
      end
   endtask

   task automatic test_alu_to_w();
      clear_mems();
      imem[0] = 16'h0007;
      imem[1] = 16'hB009;
      imem[2] = 16'h2005;
      imem[3] = 16'hA003;
      set_d(11'h7, 16'h0004);
      set_d(11'h5, 16'h0003);
      i_fix = 0; d_fix = 0;
      apply_reset();
      wait_fetches(5, 200, "alu_w");
      checks++;
      if (w !== 16'h0007 || carry !== 1'b0 || zero !== 1'b0 || pc !== 11'h3) begin
         errors++;
         $display("FAIL alu_w_state: got w=%h c=%b z=%b pc=%h, want 0007/0/0/003", w, carry, zero, pc);
      end
      checks++;
      if (last_wr_addr !== 11'h9 || last_wr_data !== 16'h0004) begin
         errors++;
         $display("FAIL movwf_write: got %h@%h, want 0004@009", last_wr_data, last_wr_addr);
      end
      checks++;
      if (fetch_cyc[1] - fetch_cyc[0] != 3 || fetch_cyc[2] - fetch_cyc[1] != 2 ||
          fetch_cyc[3] - fetch_cyc[2] != 3 || fetch_cyc[4] - fetch_cyc[3] != 2) begin
         errors++;
         $display("FAIL alu_w_cycles: got %0d,%0d,%0d,%0d, want 3,2,3,2", fetch_cyc[1] - fetch_cyc[0],
                  fetch_cyc[2] - fetch_cyc[1], fetch_cyc[3] - fetch_cyc[2], fetch_cyc[4] - fetch_cyc[3]);
      end
   endtask

   task automatic test_alu_to_mem();
      clear_mems();
      imem[0] = 16'h0008;
      imem[1] = 16'h2806;
      imem[2] = 16'hA002;
      set_d(11'h8, 16'h0001);
      set_d(11'h6, 16'hFFFF);
      i_fix = 0; d_fix = 0;
      apply_reset();
      wait_fetches(4, 200, "alu_mem");
      checks++;
      if (last_wr_addr !== 11'h6 || last_wr_data !== 16'h0000) begin
         errors++;
         $display("FAIL alu_mem_write: got %h@%h, want 0000@006", last_wr_data, last_wr_addr);
      end
      checks++;
      if (carry !== 1'b1 || zero !== 1'b1 || w !== 16'h0001) begin
         errors++;
         $display("FAIL alu_mem_state: got c=%b z=%b w=%h, want 1/1/0001", carry, zero, w);
      end
      checks++;
      if (fetch_cyc[2] - fetch_cyc[1] != 4 || fetch_addr[2] !== 11'h2) begin
         errors++;
         $display("FAIL alu_mem_retire: got %0d cycles next=%h, want 4 cycles next=002",
                  fetch_cyc[2] - fetch_cyc[1], fetch_addr[2]);
      end
   endtask

   task automatic test_pc_wrap();
      clear_mems();
      imem[0]      = 16'hA7FF;
      imem[11'h7FF] = 16'h8005;
      imem[1]      = 16'hA001;
      set_d(11'h5, 16'h0003);
      i_fix = 0; d_fix = 0;
      apply_reset();
      wait_fetches(3, 200, "wrap_skip");
      checks++;
      if (fetch_addr[1] !== 11'h7FF || fetch_addr[2] !== 11'h001 || w !== 16'h0003) begin
         errors++;
         $display("FAIL wrap_skip: got fetch %h->%h w=%h, want 7ff->001 w=0003", fetch_addr[1], fetch_addr[2], w);
      end
      set_d(11'h5, 16'h0000);
      apply_reset();
      wait_fetches(3, 200, "wrap_noskip");
      checks++;
      if (fetch_addr[1] !== 11'h7FF || fetch_addr[2] !== 11'h000) begin
         errors++;
         $display("FAIL wrap_noskip: got fetch %h->%h, want 7ff->000", fetch_addr[1], fetch_addr[2]);
      end
   endtask

   task automatic test_imem_wait();
      int bad;
      clear_mems();
      imem[0]       = 16'hA123;
      imem[11'h123] = 16'hA123;
      i_fix = 3; d_fix = 0;
      apply_reset();
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (imem_req !== 1'b1 || imem_addr !== 11'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL imem_hold: got %0d unstable cycles, want 0", bad);
      end
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL imem_drop: got imem_req=%b after ack, want 0", imem_req);
      end
      wait_fetches(2, 200, "imem_wait");
      checks++;
      if (fetch_addr[1] !== 11'h123 || pc !== 11'h123 || fetch_cyc[1] - fetch_cyc[0] != 5) begin
         errors++;
         $display("FAIL goto_wait: got fetch=%h pc=%h cycles=%0d, want 123/123/5",
                  fetch_addr[1], pc, fetch_cyc[1] - fetch_cyc[0]);
      end
      i_fix = 0;
   endtask

`ifdef EXEC_SEQ_BREAK_EN
   task automatic test_break();
      int bad;
      clear_mems();
      imem[4] = 16'h0007;
      set_d(11'h7, 16'h0055);
      i_fix = 0; d_fix = 0;
      bp_en = 1'b1;
      bp_addr = 11'h004;
      apply_reset();
      wait_fetches(4, 100, "break");
      repeat (3) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || fetch_n != 4 || pc !== 11'h4) begin
         errors++;
         $display("FAIL break_halt: got %0d bad cycles fetches=%0d pc=%h, want 0/4/004", bad, fetch_n, pc);
      end
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      wait_fetches(6, 100, "resume");
      checks++;
      if (fetch_addr[4] !== 11'h4 || fetch_addr[5] !== 11'h5 || w !== 16'h0055 || halted !== 1'b0) begin
         errors++;
         $display("FAIL break_resume: got fetch %h,%h w=%h halted=%b, want 004,005 w=0055 halted=0",
                  fetch_addr[4], fetch_addr[5], w, halted);
      end
      bp_en = 1'b0;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 2048; i++) begin
         logic [15:0] v;
         imem[i] = 16'($urandom);
         v = (i % 3 == 0) ? 16'h0 : 16'($urandom);
         set_d(11'(i), v);
      end
      i_rand = 1'b1; d_rand = 1'b1;
      apply_reset();
      wait_fetches(300, 20000, "random");
      i_rand = 1'b0; d_rand = 1'b0;
   endtask

   initial begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      imem_rdata = 16'h0;
      dmem_rdata = 16'h0;
      test_reset();
      test_alu_to_w();
      test_alu_to_mem();
      test_pc_wrap();
      test_imem_wait();
`ifdef EXEC_SEQ_BREAK_EN
      test_break();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
